// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the pipelined RISC-V core. It takes one load or
// store request from the MEM stage and performs it on an internal
// word-organised SRAM after WAIT_CYCLES wait states. While the access is in
// flight it stalls the pipeline. Loads return size-adjusted data that is
// sign- or zero-extended.
//
// Parameters
//   DEPTH_WORDS  SRAM depth in 32-bit words (power of 2)
//   WAIT_CYCLES  extra wait states per access (0..15)
//
// Ports
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   mem_read     load request from the MEM stage
//   mem_write    store request from the MEM stage (wins if both are high)
//   funct3       access size/sign field of the instruction
//   addr         byte address (ALU result)
//   wdata        store data (rs2)
//   rdata        load result, held between loads
//   rdata_valid  one-cycle pulse, load result valid
//   stall        freeze IF/ID/EX/MEM registers
//   mem_err      fault pulse (only when DMEM_ERR_EN is defined)
//
// Optional feature: define DMEM_ERR_EN to add mem_err.
//   - Misaligned half/word accesses and illegal funct3 values are faults.
//   - A faulting store does not write.
//   - A faulting load returns 0.
// Without DMEM_ERR_EN:
//   - Misaligned accesses are force-aligned.
//   - Only illegal funct3 values suppress the access.

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        stall
`ifdef DMEM_ERR_EN
    ,
    output logic        mem_err
`endif
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        store_q;

    logic [31:0] sram [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic is_illegal(input logic st, input logic [2:0] f3);
        if (st)
            return f3 > 3'b010;
        else
            return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] f3);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [31:0]        sh_b;
        logic [31:0]        sh_h;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh_b = word >> {off, 3'b000};
        sh_h = word >> {off[1], 4'b0000};
        b    = $signed(sh_b[7:0]);
        h    = $signed(sh_h[15:0]);
        case (f3)
            3'b000:  return 32'(b);
            3'b001:  return 32'(h);
            3'b010:  return word;
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return 32'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] off, input logic [2:0] f3);
        case (f3)
            3'b000:  return 4'b0001 << off;
            3'b001:  return off[1] ? 4'b1100 : 4'b0011;
            3'b010:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] d, input logic [2:0] f3);
        case (f3)
            3'b000:  return {4{d[7:0]}};
            3'b001:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Effective request
    // ------------------------------------------------------------------
    // The request is taken straight from the inputs in the accepting cycle.
    // This matters for WAIT_CYCLES=0, where the commit edge is the same edge
    // that latches the request. In every later cycle the latched copy is used.
    logic        req, accept, commit;
    logic [31:0] act_addr, act_wdata;
    logic [2:0]  act_funct3;
    logic        act_store, act_fault;
    logic [AW-1:0] act_idx;
    logic [31:0] rd_word;
    logic [3:0]  wr_be;
    logic [31:0] wr_lanes;

    assign req        = mem_read | mem_write;
    assign accept     = (state == IDLE) && req;
    assign act_addr   = accept ? addr      : addr_q;
    assign act_wdata  = accept ? wdata     : wdata_q;
    assign act_funct3 = accept ? funct3    : funct3_q;
    assign act_store  = accept ? mem_write : store_q;
    assign act_idx    = act_addr[AW+1:2];
    assign rd_word    = sram[act_idx];
    assign wr_be      = store_be(act_addr[1:0], act_funct3);
    assign wr_lanes   = store_lanes(act_wdata, act_funct3);

`ifdef DMEM_ERR_EN
    assign act_fault = is_illegal(act_store, act_funct3) ||
                       is_misaligned(act_addr[1:0], act_funct3);
`else
    assign act_fault = is_illegal(act_store, act_funct3);
`endif

    // The memory action happens on the edge that enters DONE. Gating with
    // rst_n stops a held request from writing while reset is asserted.
    assign commit = rst_n && (state != DONE) && (next_state == DONE);

    // Upper address bits select nothing; accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^act_addr[31:AW+2];

    // ------------------------------------------------------------------
    // State register and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            if (accept)
                cnt <= CNT_INIT;
            else if (state == WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = (WAIT_CYCLES == 0) ? DONE : WAIT;
            WAIT:    if (cnt == 4'd0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        stall       = rst_n && (accept || (state == WAIT));
        rdata_valid = (state == DONE) && !store_q;
`ifdef DMEM_ERR_EN
        mem_err     = (state == DONE) && act_fault;
`endif
    end

    // ------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            store_q  <= 1'b0;
        end else if (accept) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            funct3_q <= funct3;
            store_q  <= mem_write;
        end
    end

    // ------------------------------------------------------------------
    // Load result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= 32'd0;
        else if (commit && !act_store)
            rdata <= act_fault ? 32'd0 : load_extract(rd_word, act_addr[1:0], act_funct3);
    end

    // ------------------------------------------------------------------
    // SRAM write port (contents are not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (commit && act_store && !act_fault) begin
            for (int i = 0; i < 4; i++)
                if (wr_be[i])
                    sram[act_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
    end

endmodule
